// File: rtl/mux8_deserializer.sv
// Receive side of the 8:1 mux serial link: steers each accepted bit to its lane,
// rebuilds the word, and hands it to a consumer over a valid/ready port.
module mux8_deserializer #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             start,
    output logic [SEL_W-1:0] sel_out,
    output logic             busy,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [WIDTH-1:0] collect_q, collect_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] word_done;
    logic             complete;

    // start always wins: it discards any partial word and re-anchors at lane 0.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        collect_d = collect_q;
        word_done = collect_q;
        complete  = 1'b0;
        if (start) begin
            state_d   = ST_COLLECT;
            collect_d = '0;
            sel_d     = '0;
            if (bit_valid) begin
                collect_d[0] = bit_in;
                sel_d        = SEL_W'(1);
            end
        end else if (state_q == ST_COLLECT && bit_valid) begin
            word_done[sel_q] = bit_in;
            if (sel_q == SEL_W'(WIDTH - 1)) begin
                complete  = 1'b1;
                sel_d     = '0;
                state_d   = ST_IDLE;
                collect_d = '0;
            end else begin
                collect_d = word_done;
                sel_d     = sel_q + SEL_W'(1);
            end
        end
    end

    // Handshake: a word transfers on any edge where out_valid and out_ready are
    // both high; while out_valid=1 and out_ready=0 the word is held unchanged.
    // A word completing into a held, unaccepted slot is dropped with an overrun pulse.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = 1'b0;
        if (complete) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = word_done;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            collect_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            collect_q   <= collect_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign sel_out   = sel_q;
    assign busy      = (state_q == ST_COLLECT);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_mux8_deserializer.sv
// Bench for mux8_deserializer: directed frames checked against a lane-level
// reference model every cycle, plus literal expectations from hand calculation.
module tb_mux8_deserializer;

    localparam int WIDTH = 8;
    localparam int SEL_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             bit_in = 1'b0;
    logic             bit_valid = 1'b0;
    logic             start = 1'b0;
    logic             out_ready = 1'b0;
    logic [SEL_W-1:0] sel_out;
    logic             busy;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             overrun;

    int n_total = 0;
    int n_pass  = 0;

    mux8_deserializer #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .start     (start),
        .sel_out   (sel_out),
        .busy      (busy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a frame is a list of lane bits filled in arrival order.
    int               m_lane = 0;
    bit               m_in_frame = 1'b0;
    bit               m_bits[WIDTH];
    logic [WIDTH-1:0] m_held = '0;
    bit               m_valid = 1'b0;
    bit               m_overrun = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic [WIDTH-1:0] word;
        bit               done;
        if (!rst_n) begin
            m_lane     = 0;
            m_in_frame = 1'b0;
            m_held     = '0;
            m_valid    = 1'b0;
            m_overrun  = 1'b0;
            for (int k = 0; k < WIDTH; k++) m_bits[k] = 1'b0;
        end else begin
            done      = 1'b0;
            word      = '0;
            m_overrun = 1'b0;
            if (start) begin
                m_lane     = 0;
                m_in_frame = 1'b1;
                for (int k = 0; k < WIDTH; k++) m_bits[k] = 1'b0;
            end
            if (m_in_frame && bit_valid) begin
                m_bits[m_lane] = bit_in;
                m_lane++;
                if (m_lane == WIDTH) begin
                    for (int k = 0; k < WIDTH; k++) word[k] = m_bits[k];
                    done       = 1'b1;
                    m_in_frame = 1'b0;
                    m_lane     = 0;
                end
            end
            if (done) begin
                if (m_valid && !out_ready) m_overrun = 1'b1;
                else begin
                    m_held  = word;
                    m_valid = 1'b1;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("cmp_out_valid", out_valid, m_valid);
            chk("cmp_out_data", out_data, m_held);
            chk("cmp_overrun", overrun, m_overrun);
            chk("cmp_sel_out", sel_out, m_lane);
            chk("cmp_busy", busy, m_in_frame);
        end
    end

    task automatic step(input bit s, input bit bv, input bit b, input bit r);
        start     = s;
        bit_valid = bv;
        bit_in    = b;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w, input bit r, input bit r_last,
                              input int gap_after, input int gap_len);
        for (int i = 0; i < WIDTH; i++) begin
            step(i == 0, 1'b1, w[i], (i == WIDTH - 1) ? r_last : r);
            chk("sel_step", sel_out, (i + 1) % WIDTH);
            chk("busy_step", busy, (i < WIDTH - 1) ? 1 : 0);
            if (i == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    step(1'b0, 1'b0, 1'b0, r);
                    chk("sel_gap", sel_out, gap_after + 1);
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_sel"}, sel_out, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Idle bits without start are ignored
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("idle_busy", busy, 0);
        chk("idle_sel", sel_out, 0);

        // Basic frame
        send_frame(8'h63, 1'b1, 1'b1, -1, 0);
        chk("basic_data", out_data, 8'h63);
        chk("basic_valid", out_valid, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("basic_drained", out_valid, 0);

        // Gapped frame
        send_frame(8'h63, 1'b1, 1'b1, 3, 3);
        chk("gap_data", out_data, 8'h63);
        chk("gap_valid", out_valid, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Backpressure and overrun
        send_frame(8'hA5, 1'b0, 1'b0, -1, 0);
        chk("bp_valid", out_valid, 1);
        chk("bp_data", out_data, 8'hA5);
        chk("bp_overrun0", overrun, 0);
        send_frame(8'h3C, 1'b0, 1'b0, -1, 0);
        chk("ovr_pulse", overrun, 1);
        chk("ovr_data_held", out_data, 8'hA5);
        chk("ovr_valid_held", out_valid, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_pulse_end", overrun, 0);
        chk("ovr_data_still", out_data, 8'hA5);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_drained", out_valid, 0);

        // Back-to-back: transfer on the completion edge
        send_frame(8'h11, 1'b0, 1'b0, -1, 0);
        chk("b2b_first", out_data, 8'h11);
        send_frame(8'h22, 1'b0, 1'b1, -1, 0);
        chk("b2b_valid", out_valid, 1);
        chk("b2b_data", out_data, 8'h22);
        chk("b2b_overrun", overrun, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("b2b_drained", out_valid, 0);

        // Mid-frame restart: aborted ones must not leak into a zero word
        step(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("abort_sel", sel_out, 5);
        send_frame(8'h00, 1'b1, 1'b1, -1, 0);
        chk("restart0_data", out_data, 8'h00);
        chk("restart0_valid", out_valid, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Mid-frame restart with start+bit=1, word held for the reset test
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b0, -1, 0);
        chk("restart_data", out_data, 8'hFF);
        chk("restart_overrun", overrun, 0);
        chk("restart_valid", out_valid, 1);

        // Async reset mid-frame with a word held
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("prereset_sel", sel_out, 4);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h5A, 1'b1, 1'b1, -1, 0);
        chk("post_reset_data", out_data, 8'h5A);
        chk("post_reset_valid", out_valid, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("post_reset_drained", out_valid, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mux8_deserializer.md
Name: mux8_deserializer

Overview:
- Receive end of the 8:1 mux serial path. A transmitter scans its select index 0..7 and emits one lane bit per step.
- This block routes each incoming bit back to its lane (a 1:8 demux with storage), rebuilding the original 8-bit word.
- Presents the word on a valid/ready output port.
- Sits between the serial link and downstream byte consumers; also exports its current lane index for debug and lockstep checks.

Parameters:
- WIDTH, 8, number of lanes and output word width.
- SEL_W, 3, lane index width; must equal clog2(WIDTH).

Ports:
- clk, in, 1, single clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset; asserts immediately, deassertion is synchronous to clk.
- bit_in, in, 1, serial data bit.
- bit_valid, in, 1, bit_in is qualified this cycle.
- start, in, 1, frame sync. Forces lane index to 0. If bit_valid is also high, this bit is lane 0.
- sel_out, out, SEL_W, lane index the next accepted bit will be written to.
- busy, out, 1, high while the state is COLLECT.
- out_data, out, WIDTH, reconstructed word; bit i is the lane-i bit.
- out_valid, out, 1, out_data is held for consumer.
- out_ready, in, 1, consumer accepts out_data when out_valid and out_ready are both high.
- overrun, out, 1, one-cycle pulse when a completed word is dropped.

Behaviour:
- Reset values:
  - state = IDLE
  - sel_out = 0, busy = 0
  - collect register = 0
  - out_data = 0, out_valid = 0, overrun = 0
- State IDLE:
  - bit_valid without start is ignored.
  - start with bit_valid=0: go to COLLECT, sel = 0.
  - start with bit_valid=1: write bit_in to lane 0, sel = 1, go to COLLECT.
- State COLLECT:
  - Each cycle with bit_valid=1 writes bit_in to collect[sel], then sel increments.
  - Cycles with bit_valid=0 hold all state; gaps of any length are allowed.
- start while in COLLECT (mid-frame):
  - The partial word is discarded and the collect register is cleared.
  - The lane index restarts at 0, applying the same rules as in IDLE.
  - No overrun is flagged.
- Completion:
  - A bit accepted at sel = WIDTH-1 completes the word.
  - The completed word (including that bit) goes to the output register.
  - sel wraps to 0 and state returns to IDLE; every frame needs its own start.
- Latency: the last bit is sampled at edge N, and out_valid/out_data are visible after edge N (one clock).
- Output handshake:
  - out_data and out_valid are stable while out_valid=1 and out_ready=0.
  - Transfer occurs at an edge with out_valid and out_ready both high; out_valid clears next unless a new word loads the same edge.
- Completion on the same edge as a transfer: the new word loads, out_valid stays 1, no overrun.
- Completion while out_valid=1 and out_ready=0:
  - The new word is dropped and the held word is preserved.
  - overrun pulses high for exactly one cycle.
  - State returns to IDLE as normal.
- start and completion cannot coincide. start forces lane 0, which wins over completion logic, so the completing bit is treated as a new lane 0.
- Reset asserted mid-frame or mid-handshake: all outputs return to reset values immediately (async); no partial word survives.
- sel_out is a registered copy of the internal index, with no combinational path from the inputs.

Test Plan:
- Basic frame: start+bit_valid, then 7 more bits forming lane pattern 8'b0110_0011 LSB first (lanes 0..7 = 1,1,0,0,0,1,1,0), out_ready=1 → out_data=8'h63 and out_valid high one cycle after the 8th bit; sel_out steps 1..7 then 0; busy drops with completion.
- Gapped input: same frame with bit_valid low for 3 cycles between lanes 3 and 4 → out_data=8'h63; sel_out holds at 4 during the gap.
- Backpressure and overrun:
  - Send 8'hA5 with out_ready=0 → out_valid=1, out_data=8'hA5 held.
  - Send a second frame 8'h3C → overrun pulses one cycle; out_data stays 8'hA5.
  - Raise out_ready → A5 transferred, then out_valid=0.
- Back-to-back transfer: word 8'h11 held, out_ready asserted on the same edge word 8'h22 completes → out_valid stays 1, out_data=8'h22, overrun=0.
- Mid-frame restart: send 5 bits, assert start with bit_valid=1 and bit=1, then 7 bits forming 8'hFF → out_data=8'hFF; no bits from the aborted frame leak in; overrun=0.
- Async reset: drop rst_n for half a clock mid-frame after 4 bits → all outputs 0 immediately. A fresh frame 8'h5A after release → out_data=8'h5A.
